// File: rtl/out_port_fifo_if.sv
// Output-port handshake bundle: strobed datapath bus in, valid/ready head word out.
// Latency: none (wires only).
// Backpressure: consumer holds the head by keeping out_ready low.
interface out_port_fifo_if #(
  parameter int WIDTH = 32
);
  logic             OutPortIn;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] OutPort_data;
  logic             out_valid;
  logic             out_ready;

  // FIFO side
  modport slave (
    input  OutPortIn,
    input  bus,
    input  out_ready,
    output OutPort_data,
    output out_valid
  );

  // Producer/consumer side
  modport master (
    output OutPortIn,
    output bus,
    output out_ready,
    input  OutPort_data,
    input  out_valid
  );
endinterface

// File: rtl/out_port_fifo.sv
// Output-port FIFO: queues one bus word per OutPortIn rising edge, drains over valid/ready.
// Latency: a word pushed at edge k is at the head after edge k; no bus-to-head bypass.
// Backpressure: out_ready low holds the head; a strobe edge while full with no pop is dropped and sets sticky overflow.
module out_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          Clock,
  input  logic          Clear,
  out_port_fifo_if.slave port,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             strobe_q;
  logic             push_req;
  logic             pop;
  logic             push_acc;

  // Flags and head word are decoded from registered state only
  always_comb begin
    empty          = (count == '0);
    full           = (count == DEPTH_C);
    port.out_valid = ~empty;
    port.OutPort_data = empty ? '0 : mem[rd_ptr];
  end

  // Handshake decode: one push request per strobe edge; a pop frees room for a push the same cycle
  always_comb begin
    push_req = port.OutPortIn & ~strobe_q;
    pop      = port.out_valid & port.out_ready;
    push_acc = push_req & (~full | pop);
  end

  // Pointer, count, edge-detect and sticky overflow state
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= port.OutPortIn;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (push_acc && !pop)      count <= count + 1'b1;
      else if (pop && !push_acc) count <= count - 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Storage array; contents are left as-is on reset since the pointers discard them
  always_ff @(posedge Clock) begin
    if (Clear && push_acc) mem[wr_ptr] <= port.bus;
  end

endmodule
